// File: rtl/row_window_fetcher.sv
// row_window_fetcher: sweeps the read bank row by row, presenting a toroidal three-row window per handshake
module row_window_fetcher #(
  parameter int X_SIZE = 1280,
  parameter int Y_SIZE = 720,
  parameter int Y_WIDTH = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic [Y_WIDTH-1:0] fetch_addr,
  input  logic [X_SIZE-1:0]  fetch_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [X_SIZE-1:0]  row_above,
  output logic [X_SIZE-1:0]  row_curr,
  output logic [X_SIZE-1:0]  row_below,
  output logic [Y_WIDTH-1:0] win_row,
  output logic               done
);
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [CW-1:0] C_LAST = CW'(READ_LATENCY);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_SIZE - 1);
  localparam logic [Y_WIDTH-1:0] Y_PEN = Y_WIDTH'(Y_SIZE - 2);
  typedef enum logic [1:0] {IDLE, PRIME, PRESENT, FETCH} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0] phase;
  logic cap, hs, fin;
  logic [Y_WIDTH-1:0] row_nxt;
  assign cap = (state == PRIME || state == FETCH) && cnt == C_LAST;
  assign hs = state == PRESENT && win_ready;
  assign fin = hs && win_row == Y_LAST;
  // wrap explicitly: win_row+2 never exceeds Y_SIZE-1 outside the wrap case
  assign row_nxt = win_row == Y_PEN ? '0 : win_row + Y_WIDTH'(2);
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE    ? (start ? PRIME : IDLE)
              : state == PRIME   ? (cap && phase == 2'd2 ? PRESENT : PRIME)
              : state == PRESENT ? (fin ? IDLE : hs ? FETCH : PRESENT)
              :                    (cap ? PRESENT : FETCH);
    win_valid = state == PRESENT;
    busy = state != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      phase <= '0;
      fetch_addr <= '0;
      win_row <= '0;
      row_above <= '0;
      row_curr <= '0;
      row_below <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      cnt <= (state == PRIME || state == FETCH) && !cap ? cnt + CW'(1) : '0;
      if (state == IDLE && start) begin
        fetch_addr <= Y_LAST;
        win_row <= '0;
        phase <= '0;
      end
      if (state == PRIME && cap) begin
        phase <= phase + 2'd1;
        if (phase == 2'd0) begin
          row_above <= fetch_data;
          fetch_addr <= '0;
        end else if (phase == 2'd1) begin
          row_curr <= fetch_data;
          fetch_addr <= Y_WIDTH'(1);
        end else row_below <= fetch_data;
      end
      if (hs && !fin) begin
        row_above <= row_curr;
        row_curr <= row_below;
        win_row <= win_row + Y_WIDTH'(1);
        fetch_addr <= row_nxt;
      end
      if (state == FETCH && cap) row_below <= fetch_data;
    end
  end
endmodule

// File: tb/tb_row_window_fetcher.sv
// tb_row_window_fetcher: randomized directed sweeps against a row-level window model, for L=2 and L=1
module tb_row_window_fetcher;
  localparam int Y = 4;
  localparam int X = 8;
  localparam int W = 3;
  logic clk, rst, start, ready, sel;
  logic [7:0] mem [8];
  logic [W-1:0] a_addr, b_addr, a_row, b_row, pa1, pa2, pb1;
  logic [X-1:0] a_data, b_data, a_above, a_curr, a_below, b_above, b_curr, b_below;
  logic a_busy, a_valid, a_done, b_busy, b_valid, b_done;
  logic [W-1:0] o_addr, o_row;
  logic [X-1:0] o_above, o_curr, o_below;
  logic o_busy, o_valid, o_done;
  int total, bad, done_seen, exp_done;
  row_window_fetcher #(.X_SIZE(X), .Y_SIZE(Y), .Y_WIDTH(W), .READ_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(a_busy), .fetch_addr(a_addr), .fetch_data(a_data),
    .win_valid(a_valid), .win_ready(ready), .row_above(a_above), .row_curr(a_curr),
    .row_below(a_below), .win_row(a_row), .done(a_done));
  row_window_fetcher #(.X_SIZE(X), .Y_SIZE(Y), .Y_WIDTH(W), .READ_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(b_busy), .fetch_addr(b_addr), .fetch_data(b_data),
    .win_valid(b_valid), .win_ready(ready), .row_above(b_above), .row_curr(b_curr),
    .row_below(b_below), .win_row(b_row), .done(b_done));
  always @(posedge clk) begin
    pa1 <= a_addr;
    pa2 <= pa1;
    pb1 <= b_addr;
  end
  assign a_data = mem[pa2];
  assign b_data = mem[pb1];
  assign o_addr = sel ? b_addr : a_addr;
  assign o_row = sel ? b_row : a_row;
  assign o_above = sel ? b_above : a_above;
  assign o_curr = sel ? b_curr : a_curr;
  assign o_below = sel ? b_below : a_below;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_done = sel ? b_done : a_done;
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (o_done) done_seen++;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_row"}, o_row, 0);
    chk({tag, "_above"}, o_above, 0);
    chk({tag, "_curr"}, o_curr, 0);
    chk({tag, "_below"}, o_below, 0);
  endtask
  task automatic chk_win(input string tag, input int r);
    chk({tag, "_valid"}, o_valid, 1);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_above"}, o_above, mem[(r + Y - 1) % Y]);
    chk({tag, "_curr"}, o_curr, mem[r]);
    chk({tag, "_below"}, o_below, mem[(r + 1) % Y]);
    chk({tag, "_row"}, o_row, r);
    chk({tag, "_addr"}, o_addr, (r + 1) % Y);
  endtask
  task automatic randomize_mem();
    for (int k = 0; k < 8; k++) mem[k] = k < Y ? 8'(($urandom_range(0, 63) << 2) | k) : 8'hEE;
  endtask
  task automatic directed_mem();
    for (int k = 0; k < 8; k++) mem[k] = k < Y ? 8'(8'h10 + k) : 8'hEE;
  endtask
  task automatic idle_step();
    start = 0;
    @(negedge clk);
    chk("idle_done", o_done, 0);
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_valid, 0);
    chk("idle_addr", o_addr, 0);
  endtask
  task automatic sweep(input int stall_win, input int stall_len, input bit dup, input int abort_at);
    int lat, c;
    lat = sel ? 1 : 2;
    start = 1;
    @(negedge clk);
    c = 1;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k <= lat; k++) begin
        chk("prime_addr", o_addr, p == 0 ? Y - 1 : p - 1);
        chk("prime_valid", o_valid, 0);
        chk("prime_busy", o_busy, 1);
        chk("prime_done", o_done, 0);
        start = dup && c == 4;
        ready = 1'($urandom);
        @(negedge clk);
        c++;
      end
    for (int r = 0; r < Y; r++) begin
      ready = 1;
      chk_win("win", r);
      if (r == abort_at) begin
        rst = 1;
        start = 1;
        @(negedge clk);
        chk_zero("after_rst");
        rst = 0;
        start = 0;
        @(negedge clk);
        chk("rst_start_ignored_busy", o_busy, 0);
        chk("rst_no_done", o_done, 0);
        return;
      end
      if (r == stall_win) begin
        ready = 0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk_win("stall", r);
        end
        ready = 1;
      end
      @(negedge clk);
      if (r < Y - 1) begin
        for (int k = 0; k <= lat; k++) begin
          chk("fetch_valid", o_valid, 0);
          chk("fetch_addr", o_addr, (r + 2) % Y);
          chk("fetch_busy", o_busy, 1);
          ready = 1'($urandom);
          @(negedge clk);
        end
      end else begin
        chk("final_done", o_done, 1);
        chk("final_busy", o_busy, 0);
        chk("final_valid", o_valid, 0);
        exp_done++;
      end
    end
  endtask
  initial begin
    total = 0;
    bad = 0;
    done_seen = 0;
    exp_done = 0;
    rst = 1;
    start = 0;
    ready = 0;
    sel = 0;
    directed_mem();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);
    chk_zero("post_reset");
    sweep(-1, 0, 0, -1);
    idle_step();
    randomize_mem();
    sweep(1, 5, 0, -1);
    idle_step();
    sweep(-1, 0, 1, -1);
    sweep(-1, 0, 0, -1);
    idle_step();
    directed_mem();
    sweep(-1, 0, 0, 2);
    sweep(-1, 0, 0, -1);
    idle_step();
    chk("done_count_a", done_seen, exp_done);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sel = 1;
    @(negedge clk);
    chk_zero("reset_b");
    sweep(-1, 0, 0, -1);
    idle_step();
    randomize_mem();
    sweep(2, 4, 1, -1);
    sweep(-1, 0, 0, -1);
    idle_step();
    chk("done_count_b", done_seen, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/row_window_fetcher.md
# row_window_fetcher

Read-side sweep controller for the ping-pong generation BRAMs. On each generation it fetches rows from the current read bank through the line-buffer fetch port. It keeps a three-row toroidal window (above/current/below) and hands each window to the parallel next-state logic over a valid/ready handshake. It signals `done` after the last window so the top level can flip the bank-select `mode`.

## Interface
- `X_SIZE`, 1280, cells per row (row word width)
- `Y_SIZE`, 720, rows per frame; must be ≥ 3
- `Y_WIDTH`, 10, row address width
- `READ_LATENCY`, 2, cycles from `fetch_addr` change to valid `fetch_data`; must be ≥ 1

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  begin a sweep; sampled only while `busy`=0
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `fetch_addr`  out  Y_WIDTH  row address to the read bank (drives line-buffer fetch address)
- `fetch_data`  in  X_SIZE  row data from the read bank (line-buffer fetch memory)
- `win_valid`  out  1  window outputs valid
- `win_ready`  in  1  next-state logic accepts the window
- `row_above`  out  X_SIZE  row (r−1) mod Y_SIZE
- `row_curr`  out  X_SIZE  row r
- `row_below`  out  X_SIZE  row (r+1) mod Y_SIZE
- `win_row`  out  Y_WIDTH  r; the downstream uses it as the next-state write address
- `done`  out  1  one-cycle pulse after the final window handshake

## Operation
- FSM states: IDLE, PRIME, PRESENT, FETCH.
- IDLE: `start`=1 → PRIME, `busy`←1, `win_row`←0.
- PRIME performs three sequential fetches of rows Y_SIZE−1, 0, 1 into above, curr and below, in that order. It then goes to PRESENT.
- Fetch sub-sequence:
  - Drive `fetch_addr` for READ_LATENCY+1 cycles.
  - Capture `fetch_data` in the last of those cycles.
  - Only one fetch is in flight; the address is held constant for the whole fetch.
- PRESENT: `win_valid`=1.
  - On `win_valid && win_ready` with `win_row` < Y_SIZE−1: shift above←curr, curr←below; `win_row`+1.
  - Then go to FETCH for row (`win_row`+2) mod Y_SIZE, captured into below. Wrap: after accepting r=Y_SIZE−2, row 0 is refetched.
  - On handshake with `win_row`=Y_SIZE−1: go to IDLE, pulse `done`, `busy`←0.
- FETCH → PRESENT after capture.
- Address arithmetic is modulo Y_SIZE, explicitly wrapped. It never relies on 2^Y_WIDTH overflow.
- The read bank is not written during a sweep; the block has no knowledge of `mode`.

## Timing
- Reset values: `busy`=0, `win_valid`=0, `done`=0, `fetch_addr`=0, `win_row`=0, all row outputs 0. State is IDLE.
- `rst` mid-sweep aborts immediately: no `done`, and the next sweep starts from PRIME.
- L = READ_LATENCY. Take `start` sampled high at edge 0:
  - `fetch_addr`=Y_SIZE−1 during cycles 1..1+L.
  - `fetch_addr`=0 during cycles 2+L..2+2L.
  - `fetch_addr`=1 during cycles 3+2L..3+3L.
  - `win_valid` first high in cycle 4+3L (10 for L=2).
- Handshake in cycle h (not final):
  - `win_valid`=0 from h+1.
  - New `fetch_addr` during h+1..h+1+L.
  - `win_valid`=1 in h+2+L.
  - Window throughput is 1 per L+2 cycles with `win_ready` tied high.
- While `win_valid`=1 and `win_ready`=0, all window outputs and `win_row` hold stable.
- `win_ready` while `win_valid`=0 is ignored.
- Final handshake in cycle h: `done`=1 and `busy`=0 in h+1. `start` in h+1 is accepted.
- `start` while `busy`=1 is ignored. `start` coincident with `rst` is ignored.
- `fetch_addr` holds its last value in IDLE.

## Test plan
- Basic sweep. Setup: Y_SIZE=4, X_SIZE=8, L=2; BRAM model with row k = 8'h10+k; `win_ready`=1; `start` pulse.
  - Windows in order (above, curr, below, `win_row`): (13,10,11,0), (10,11,12,1), (11,12,13,2), (12,13,10,3).
  - First `win_valid` at cycle 10.
  - `done` one cycle after the 4th handshake.
  - Exactly 6 distinct fetch address phases: 3,0,1,2,3,0.
- Backpressure: hold `win_ready`=0 for 5 cycles on window 1 → outputs and `win_row` unchanged throughout; no new `fetch_addr` until the handshake.
- Latency parameter: L=1, same data → first `win_valid` at cycle 7; spacing between windows = 3 cycles.
- Start while busy: pulse `start` at cycles 0 and 5 → a single sweep of 4 windows; one `done`.
- Reset mid-sweep: assert `rst` during window 2, then `start` again.
  - All outputs 0 in the cycle after reset; no `done`.
  - The new sweep begins with `fetch_addr`=3 and the first window is (13,10,11,0).
- Back-to-back: `start` asserted in the `done` cycle → second sweep accepted; `busy` high the following cycle.
